// File: rtl/wb_stage.sv
// Writeback stage: formats MEM results, buffers mul/div results, arbitrates the single
// register-file write port and counts retired instructions.
module wb_stage #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned MD_FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  logic            mem_reg_write_i,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic [1:0]      mem_to_reg_i,
  input  logic [XLEN-1:0] mem_alu_result_i,
  input  logic [XLEN-1:0] mem_load_data_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic [XLEN-1:0] mem_pc_i,
  input  logic            md_valid_i,
  output logic            md_ready_o,
  input  logic [4:0]      md_rd_addr_i,
  input  logic [XLEN-1:0] md_result_i,
  output logic            wb_reg_write_en_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic [XLEN-1:0] wb_result_o,
  output logic            wb_retire_o,
  output logic [63:0]     instret_o,
  output logic            md_pending_o
);

  localparam int unsigned PtrW = (MD_FIFO_DEPTH > 1) ? $clog2(MD_FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(MD_FIFO_DEPTH + 1);

  logic [4:0]      r_fifo_rd   [MD_FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_data [MD_FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_d, w_rd_ptr_d;
  logic [CntW-1:0] r_count, w_count_d;

  logic            r_wb_we, w_wb_we_d;
  logic [4:0]      r_wb_rd, w_wb_rd_d;
  logic [XLEN-1:0] r_wb_result, w_wb_result_d;
  logic            r_retire;
  logic [63:0]     r_instret;

  logic            w_mem_xfer, w_md_xfer, w_pop;
  logic [XLEN-1:0] w_mem_result;

  function automatic logic [PtrW-1:0] f_ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MD_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] data, input logic [1:0] off,
                                         input logic [2:0] f3);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = data >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? data[31:16] : data[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return data;
    endcase
  endfunction

  assign mem_ready_o  = (r_count == '0);
  assign md_ready_o   = (r_count < CntW'(MD_FIFO_DEPTH));
  assign md_pending_o = (r_count != '0);

  assign w_mem_xfer = mem_valid_i && mem_ready_o;
  assign w_md_xfer  = md_valid_i && md_ready_o;
  assign w_pop      = (r_count != '0);

  always_comb begin
    case (mem_to_reg_i)
      2'b01:   w_mem_result = f_load(mem_load_data_i, mem_alu_result_i[1:0], mem_funct3_i);
      2'b10:   w_mem_result = mem_pc_i + 32'd4;
      default: w_mem_result = mem_alu_result_i;
    endcase
  end

  always_comb begin
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    w_count_d  = r_count;
    if (w_md_xfer) w_wr_ptr_d = f_ptr_inc(r_wr_ptr);
    if (w_pop)     w_rd_ptr_d = f_ptr_inc(r_rd_ptr);
    case ({w_md_xfer, w_pop})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  // Buffered mul/div results take priority; MEM is already stalled by mem_ready_o.
  always_comb begin
    w_wb_we_d     = 1'b0;
    w_wb_rd_d     = r_wb_rd;
    w_wb_result_d = r_wb_result;
    if (w_pop) begin
      w_wb_we_d     = (r_fifo_rd[r_rd_ptr] != 5'd0);
      w_wb_rd_d     = r_fifo_rd[r_rd_ptr];
      w_wb_result_d = r_fifo_data[r_rd_ptr];
    end else if (w_mem_xfer) begin
      w_wb_we_d     = mem_reg_write_i && (mem_rd_addr_i != 5'd0);
      w_wb_rd_d     = mem_rd_addr_i;
      w_wb_result_d = w_mem_result;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_md_xfer) begin
      r_fifo_rd[r_wr_ptr]   <= md_rd_addr_i;
      r_fifo_data[r_wr_ptr] <= md_result_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_result <= '0;
      r_retire    <= 1'b0;
      r_instret   <= 64'd0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_d;
      r_rd_ptr    <= w_rd_ptr_d;
      r_count     <= w_count_d;
      r_wb_we     <= w_wb_we_d;
      r_wb_rd     <= w_wb_rd_d;
      r_wb_result <= w_wb_result_d;
      r_retire    <= w_mem_xfer;
      if (w_mem_xfer) r_instret <= r_instret + 64'd1;
    end
  end

  assign wb_reg_write_en_o = r_wb_we;
  assign wb_rd_addr_o      = r_wb_rd;
  assign wb_result_o       = r_wb_result;
  assign wb_retire_o       = r_retire;
  assign instret_o         = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; a second depth-1 instance exercises the
// full-buffer back-pressure case.
`timescale 1ns/1ps
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        mem_valid, mem_reg_write, md_valid;
  logic [4:0]  mem_rd, md_rd;
  logic [1:0]  mem_to_reg;
  logic [31:0] mem_alu, mem_data, mem_pc, md_result;
  logic [2:0]  mem_f3;

  logic        mem_ready, md_ready, wb_we, retire, pending;
  logic [4:0]  wb_rd;
  logic [31:0] wb_res;
  logic [63:0] instret;

  logic        o1_mem_ready, o1_md_ready, o1_we, o1_retire, o1_pending;
  logic [4:0]  o1_rd;
  logic [31:0] o1_res;
  logic [63:0] o1_instret;

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] exp_instret = 64'd0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .MD_FIFO_DEPTH(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready),
    .mem_reg_write_i(mem_reg_write), .mem_rd_addr_i(mem_rd), .mem_to_reg_i(mem_to_reg),
    .mem_alu_result_i(mem_alu), .mem_load_data_i(mem_data), .mem_funct3_i(mem_f3),
    .mem_pc_i(mem_pc),
    .md_valid_i(md_valid), .md_ready_o(md_ready), .md_rd_addr_i(md_rd),
    .md_result_i(md_result),
    .wb_reg_write_en_o(wb_we), .wb_rd_addr_o(wb_rd), .wb_result_o(wb_res),
    .wb_retire_o(retire), .instret_o(instret), .md_pending_o(pending)
  );

  wb_stage #(.XLEN(32), .MD_FIFO_DEPTH(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni),
    .mem_valid_i(mem_valid), .mem_ready_o(o1_mem_ready),
    .mem_reg_write_i(mem_reg_write), .mem_rd_addr_i(mem_rd), .mem_to_reg_i(mem_to_reg),
    .mem_alu_result_i(mem_alu), .mem_load_data_i(mem_data), .mem_funct3_i(mem_f3),
    .mem_pc_i(mem_pc),
    .md_valid_i(md_valid), .md_ready_o(o1_md_ready), .md_rd_addr_i(md_rd),
    .md_result_i(md_result),
    .wb_reg_write_en_o(o1_we), .wb_rd_addr_o(o1_rd), .wb_result_o(o1_res),
    .wb_retire_o(o1_retire), .instret_o(o1_instret), .md_pending_o(o1_pending)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_reg_write = 1'b0; mem_rd = 5'd0; mem_to_reg = 2'b00;
    mem_alu = 32'h0; mem_data = 32'h0; mem_f3 = 3'b000; mem_pc = 32'h0;
    md_valid = 1'b0; md_rd = 5'd0; md_result = 32'h0;
  endtask

  task automatic set_mem(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] data,
                         input logic [31:0] pc);
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = rd; mem_to_reg = sel;
    mem_f3 = f3; mem_alu = alu; mem_data = data; mem_pc = pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    tick();
    n_chk++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %0b want 0", wb_we); end
    n_chk++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL rst_rd got %0d want 0", wb_rd); end
    n_chk++; if (wb_res !== 32'h0) begin n_fail++; $display("FAIL rst_res got %h want 0", wb_res); end
    n_chk++; if (retire !== 1'b0) begin n_fail++; $display("FAIL rst_retire got %0b want 0", retire); end
    n_chk++; if (instret !== 64'd0) begin n_fail++; $display("FAIL rst_instret got %0d want 0", instret); end
    n_chk++; if (pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending got %0b want 0", pending); end
    n_chk++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mem_ready got %0b want 1", mem_ready); end
    n_chk++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL rst_md_ready got %0b want 1", md_ready); end
    rst_ni = 1'b1;
    tick();
    n_chk++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL post_rst_we got %0b want 0", wb_we); end
  endtask

  task automatic test_rd_zero();
    set_mem(5'd0, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0);
    tick();
    exp_instret++;
    n_chk++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL rd0_we got %0b want 0", wb_we); end
    n_chk++; if (retire !== 1'b1) begin n_fail++; $display("FAIL rd0_retire got %0b want 1", retire); end
    n_chk++; if (instret !== 64'd1) begin n_fail++; $display("FAIL rd0_instret got %0d want 1", instret); end
    idle_inputs();
    tick();
    n_chk++; if (retire !== 1'b0) begin n_fail++; $display("FAIL rd0_retire_end got %0b want 0", retire); end
    n_chk++; if (instret !== 64'd1) begin n_fail++; $display("FAIL rd0_instret_hold got %0d want 1", instret); end
  endtask

  task automatic test_load_byte();
    set_mem(5'd5, 2'b01, 3'b000, 32'h1003, 32'h80AA_BBCC, 32'h0);
    tick();
    exp_instret++;
    n_chk++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL lb_we got %0b want 1", wb_we); end
    n_chk++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL lb_rd got %0d want 5", wb_rd); end
    n_chk++; if (wb_res !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_res got %h want ffffff80", wb_res); end
    n_chk++; if (retire !== 1'b1) begin n_fail++; $display("FAIL lb_retire got %0b want 1", retire); end
    mem_f3 = 3'b100;
    tick();
    exp_instret++;
    n_chk++; if (wb_res !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_res got %h want 00000080", wb_res); end
    mem_f3 = 3'b000; mem_alu = 32'h1001;
    tick();
    exp_instret++;
    n_chk++; if (wb_res !== 32'h0000_00BB - 32'h100) begin n_fail++; $display("FAIL lb_off1_res got %h want ffffffbb", wb_res); end
    idle_inputs();
    tick();
    n_chk++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL idle_we got %0b want 0", wb_we); end
    n_chk++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL idle_rd_hold got %0d want 5", wb_rd); end
    n_chk++; if (wb_res !== 32'hFFFF_FFBB) begin n_fail++; $display("FAIL idle_res_hold got %h want ffffffbb", wb_res); end
    n_chk++; if (instret !== exp_instret) begin n_fail++; $display("FAIL lb_instret got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_load_half_jal();
    set_mem(5'd7, 2'b01, 3'b001, 32'h0000_2002, 32'h8001_7FFF, 32'h0);
    tick();
    n_chk++; if (wb_res !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_res got %h want ffff8001", wb_res); end
    mem_f3 = 3'b101;
    tick();
    n_chk++; if (wb_res !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_res got %h want 00008001", wb_res); end
    mem_f3 = 3'b001; mem_alu = 32'h0000_2000;
    tick();
    n_chk++; if (wb_res !== 32'h0000_7FFF) begin n_fail++; $display("FAIL lh_off0_res got %h want 00007fff", wb_res); end
    set_mem(5'd8, 2'b01, 3'b010, 32'h0000_0003, 32'h1234_5678, 32'h0);
    tick();
    n_chk++; if (wb_res !== 32'h1234_5678) begin n_fail++; $display("FAIL lw_res got %h want 12345678", wb_res); end
    set_mem(5'd1, 2'b10, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFC);
    tick();
    n_chk++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL jal_we got %0b want 1", wb_we); end
    n_chk++; if (wb_rd !== 5'd1) begin n_fail++; $display("FAIL jal_rd got %0d want 1", wb_rd); end
    n_chk++; if (wb_res !== 32'h0) begin n_fail++; $display("FAIL jal_res got %h want 0", wb_res); end
    set_mem(5'd2, 2'b11, 3'b000, 32'hCAFE_0001, 32'h0, 32'h100);
    tick();
    n_chk++; if (wb_res !== 32'hCAFE_0001) begin n_fail++; $display("FAIL sel11_res got %h want cafe0001", wb_res); end
    mem_reg_write = 1'b0; mem_rd = 5'd9;
    tick();
    n_chk++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL nowrite_we got %0b want 0", wb_we); end
    n_chk++; if (retire !== 1'b1) begin n_fail++; $display("FAIL nowrite_retire got %0b want 1", retire); end
    exp_instret += 7;
    idle_inputs();
    tick();
    n_chk++; if (instret !== exp_instret) begin n_fail++; $display("FAIL lh_instret got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_mem_md_same_cycle();
    set_mem(5'd3, 2'b00, 3'b000, 32'h11, 32'h0, 32'h0);
    md_valid = 1'b1; md_rd = 5'd4; md_result = 32'h22;
    n_chk++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL same_md_ready got %0b want 1", md_ready); end
    tick();
    // MEM held valid with a new payload: it must stall while the MD result drains.
    set_mem(5'd9, 2'b00, 3'b000, 32'h99, 32'h0, 32'h0);
    md_valid = 1'b0;
    n_chk++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL same_n1_we got %0b want 1", wb_we); end
    n_chk++; if (wb_rd !== 5'd3) begin n_fail++; $display("FAIL same_n1_rd got %0d want 3", wb_rd); end
    n_chk++; if (wb_res !== 32'h11) begin n_fail++; $display("FAIL same_n1_res got %h want 11", wb_res); end
    n_chk++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL same_n1_mem_ready got %0b want 0", mem_ready); end
    n_chk++; if (pending !== 1'b1) begin n_fail++; $display("FAIL same_n1_pending got %0b want 1", pending); end
    tick();
    n_chk++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL same_n2_we got %0b want 1", wb_we); end
    n_chk++; if (wb_rd !== 5'd4) begin n_fail++; $display("FAIL same_n2_rd got %0d want 4", wb_rd); end
    n_chk++; if (wb_res !== 32'h22) begin n_fail++; $display("FAIL same_n2_res got %h want 22", wb_res); end
    n_chk++; if (retire !== 1'b0) begin n_fail++; $display("FAIL same_n2_retire got %0b want 0", retire); end
    n_chk++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL same_n2_mem_ready got %0b want 1", mem_ready); end
    tick();
    idle_inputs();
    exp_instret += 2;
    n_chk++; if (wb_rd !== 5'd9) begin n_fail++; $display("FAIL same_n3_rd got %0d want 9", wb_rd); end
    n_chk++; if (wb_res !== 32'h99) begin n_fail++; $display("FAIL same_n3_res got %h want 99", wb_res); end
    n_chk++; if (instret !== exp_instret) begin n_fail++; $display("FAIL same_instret got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_back_to_back();
    tick();
    md_valid = 1'b1; md_rd = 5'd10; md_result = 32'hA0;
    tick();
    md_rd = 5'd11; md_result = 32'hB1;
    n_chk++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL b2b_e1_we got %0b want 0", wb_we); end
    n_chk++; if (pending !== 1'b1) begin n_fail++; $display("FAIL b2b_e1_pending got %0b want 1", pending); end
    n_chk++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_e1_md_ready got %0b want 1", md_ready); end
    tick();
    md_rd = 5'd12; md_result = 32'hC2;
    n_chk++; if (wb_rd !== 5'd10 || wb_res !== 32'hA0) begin n_fail++; $display("FAIL b2b_a got x%0d=%h want x10=a0", wb_rd, wb_res); end
    tick();
    md_valid = 1'b0;
    n_chk++; if (wb_rd !== 5'd11 || wb_res !== 32'hB1) begin n_fail++; $display("FAIL b2b_b got x%0d=%h want x11=b1", wb_rd, wb_res); end
    n_chk++; if (pending !== 1'b1) begin n_fail++; $display("FAIL b2b_e3_pending got %0b want 1", pending); end
    tick();
    n_chk++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL b2b_c_we got %0b want 1", wb_we); end
    n_chk++; if (wb_rd !== 5'd12 || wb_res !== 32'hC2) begin n_fail++; $display("FAIL b2b_c got x%0d=%h want x12=c2", wb_rd, wb_res); end
    n_chk++; if (pending !== 1'b0) begin n_fail++; $display("FAIL b2b_e4_pending got %0b want 0", pending); end
    tick();
    n_chk++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL b2b_e5_we got %0b want 0", wb_we); end
    md_valid = 1'b1; md_rd = 5'd0; md_result = 32'hEE;
    tick();
    md_valid = 1'b0;
    tick();
    n_chk++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL md_rd0_we got %0b want 0", wb_we); end
    n_chk++; if (pending !== 1'b0) begin n_fail++; $display("FAIL md_rd0_pending got %0b want 0", pending); end
  endtask

  task automatic test_reset_mid_op();
    set_mem(5'd21, 2'b00, 3'b000, 32'h33, 32'h0, 32'h0);
    md_valid = 1'b1; md_rd = 5'd20; md_result = 32'h77;
    tick();
    exp_instret++;
    idle_inputs();
    n_chk++; if (pending !== 1'b1) begin n_fail++; $display("FAIL rmid_pending_pre got %0b want 1", pending); end
    n_chk++; if (instret !== exp_instret) begin n_fail++; $display("FAIL rmid_instret_pre got %0d want %0d", instret, exp_instret); end
    rst_ni = 1'b0;
    #1;
    n_chk++; if (instret !== 64'd0) begin n_fail++; $display("FAIL rmid_instret got %0d want 0", instret); end
    n_chk++; if (pending !== 1'b0) begin n_fail++; $display("FAIL rmid_pending got %0b want 0", pending); end
    n_chk++; if (mem_ready !== 1'b1 || md_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_readys got %0b%0b want 11", mem_ready, md_ready); end
    n_chk++; if (wb_we !== 1'b0 || wb_res !== 32'h0) begin n_fail++; $display("FAIL rmid_wb got %0b/%h want 0/0", wb_we, wb_res); end
    tick();
    rst_ni = 1'b1;
    tick();
    n_chk++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL rmid_post_we got %0b want 0", wb_we); end
    n_chk++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL rmid_post_rd got %0d want 0", wb_rd); end
    n_chk++; if (instret !== 64'd0) begin n_fail++; $display("FAIL rmid_post_instret got %0d want 0", instret); end
    exp_instret = 64'd0;
  endtask

  task automatic test_full_depth1();
    md_valid = 1'b1; md_rd = 5'd12; md_result = 32'hC2;
    n_chk++; if (o1_md_ready !== 1'b1) begin n_fail++; $display("FAIL d1_ready0 got %0b want 1", o1_md_ready); end
    tick();
    md_rd = 5'd13; md_result = 32'hD3;
    n_chk++; if (o1_md_ready !== 1'b0) begin n_fail++; $display("FAIL d1_full_ready got %0b want 0", o1_md_ready); end
    n_chk++; if (o1_pending !== 1'b1) begin n_fail++; $display("FAIL d1_pending got %0b want 1", o1_pending); end
    tick();
    n_chk++; if (o1_we !== 1'b1 || o1_rd !== 5'd12 || o1_res !== 32'hC2) begin n_fail++; $display("FAIL d1_c got %0b x%0d=%h want 1 x12=c2", o1_we, o1_rd, o1_res); end
    n_chk++; if (o1_md_ready !== 1'b1) begin n_fail++; $display("FAIL d1_drained_ready got %0b want 1", o1_md_ready); end
    tick();
    md_valid = 1'b0;
    n_chk++; if (o1_we !== 1'b0) begin n_fail++; $display("FAIL d1_gap_we got %0b want 0", o1_we); end
    n_chk++; if (o1_md_ready !== 1'b0) begin n_fail++; $display("FAIL d1_refill_ready got %0b want 0", o1_md_ready); end
    tick();
    n_chk++; if (o1_we !== 1'b1 || o1_rd !== 5'd13 || o1_res !== 32'hD3) begin n_fail++; $display("FAIL d1_d got %0b x%0d=%h want 1 x13=d3", o1_we, o1_rd, o1_res); end
    n_chk++; if (o1_pending !== 1'b0) begin n_fail++; $display("FAIL d1_end_pending got %0b want 0", o1_pending); end
  endtask

  initial begin
    test_reset();
    test_rd_zero();
    test_load_byte();
    test_load_half_jal();
    test_mem_md_same_cycle();
    test_back_to_back();
    test_reset_mid_op();
    test_full_depth1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
